// File: rtl/cache_controller.sv
// Sequencing FSM for the direct-mapped cache datapath: walks a run of consecutive
// addresses, issuing hit-check, fill and read strobes, and counts misses.
module cache_controller #(
    parameter int unsigned MEM_LATENCY = 4,
    parameter int unsigned ADDR_W      = 15,
    parameter int unsigned CNT_W       = 13
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              start,
    input  logic [ADDR_W-1:0] baseAddr,
    input  logic [CNT_W-1:0]  numAccesses,
    input  logic              hit,
    output logic [ADDR_W-1:0] address,
    output logic              checkHit,
    output logic              readCache,
    output logic              writeCache,
    output logic              readMem,
    output logic              hitCountEn,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  missCount
);

    localparam int unsigned LAT_W = 4;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_HIT   = 3'd2;
    localparam logic [2:0] S_MEM   = 3'd3;
    localparam logic [2:0] S_FILL  = 3'd4;
    localparam logic [2:0] S_RDOUT = 3'd5;
    localparam logic [2:0] S_NEXT  = 3'd6;
    localparam logic [2:0] S_DONE  = 3'd7;

    logic [2:0]        state;
    logic [2:0]        next_state;
    logic [CNT_W-1:0]  remaining;
    logic [CNT_W-1:0]  remaining_nxt;
    logic [ADDR_W-1:0] address_nxt;
    logic [CNT_W-1:0]  miss_nxt;
    logic [LAT_W-1:0]  mem_cnt;
    logic [LAT_W-1:0]  mem_cnt_nxt;
    logic              check_nxt;
    logic              read_nxt;
    logic              write_nxt;
    logic              mem_nxt;
    logic              hcen_nxt;
    logic              busy_nxt;
    logic              done_nxt;

    // Next-state, datapath counters, and strobes decoded from the upcoming state
    always_comb begin
        next_state    = state;
        address_nxt   = address;
        remaining_nxt = remaining;
        miss_nxt      = missCount;
        mem_cnt_nxt   = mem_cnt;

        case (state)
            S_IDLE: begin
                if (start) begin
                    address_nxt   = baseAddr;
                    remaining_nxt = numAccesses;
                    miss_nxt      = '0;
                    next_state    = (numAccesses == '0) ? S_DONE : S_CHECK;
                end
            end
            S_CHECK: begin
                if (hit) begin
                    next_state = S_HIT;
                end else begin
                    next_state  = S_MEM;
                    mem_cnt_nxt = LAT_W'(MEM_LATENCY - 1);
                end
            end
            S_HIT:   next_state = S_NEXT;
            S_MEM: begin
                if (mem_cnt == '0) begin
                    next_state = S_FILL;
                end else begin
                    mem_cnt_nxt = mem_cnt - LAT_W'(1);
                end
            end
            S_FILL:  next_state = S_RDOUT;
            S_RDOUT: begin
                if (missCount != '1) begin
                    miss_nxt = missCount + CNT_W'(1);
                end
                next_state = S_NEXT;
            end
            S_NEXT: begin
                address_nxt   = address + ADDR_W'(1);
                remaining_nxt = remaining - CNT_W'(1);
                next_state    = (remaining == CNT_W'(1)) ? S_DONE : S_CHECK;
            end
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase

        check_nxt = (next_state == S_CHECK);
        read_nxt  = (next_state == S_HIT) || (next_state == S_RDOUT);
        write_nxt = (next_state == S_FILL);
        mem_nxt   = (next_state == S_MEM);
        hcen_nxt  = (next_state == S_HIT);
        busy_nxt  = (next_state != S_IDLE);
        done_nxt  = (next_state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state      <= S_IDLE;
            address    <= '0;
            remaining  <= '0;
            missCount  <= '0;
            mem_cnt    <= '0;
            checkHit   <= 1'b0;
            readCache  <= 1'b0;
            writeCache <= 1'b0;
            readMem    <= 1'b0;
            hitCountEn <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= next_state;
            address    <= address_nxt;
            remaining  <= remaining_nxt;
            missCount  <= miss_nxt;
            mem_cnt    <= mem_cnt_nxt;
            checkHit   <= check_nxt;
            readCache  <= read_nxt;
            writeCache <= write_nxt;
            readMem    <= mem_nxt;
            hitCountEn <= hcen_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
        end
    end

endmodule

// File: tb/tb_cache_controller.sv
// Scoreboard bench for cache_controller: a behavioural cache/run model predicts
// address order, run length, miss and hit counts; a monitor checks them.
module tb_cache_controller;

    localparam int unsigned MEM_LAT = 4;
    localparam int unsigned AW      = 15;
    localparam int unsigned CW      = 13;

    logic          clk = 1'b0;
    logic          rstN = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] baseAddr = '0;
    logic [CW-1:0] numAccesses = '0;
    logic          hit;
    logic [AW-1:0] address;
    logic          checkHit, readCache, writeCache, readMem, hitCountEn, busy, done;
    logic [CW-1:0] missCount;

    cache_controller #(.MEM_LATENCY(MEM_LAT), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .rstN(rstN), .start(start), .baseAddr(baseAddr),
        .numAccesses(numAccesses), .hit(hit), .address(address),
        .checkHit(checkHit), .readCache(readCache), .writeCache(writeCache),
        .readMem(readMem), .hitCountEn(hitCountEn), .busy(busy), .done(done),
        .missCount(missCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned cyc;
        int unsigned miss;
        int unsigned hits;
        int unsigned hbase;
    } done_t;

    int unsigned   total = 0;
    int unsigned   bad = 0;
    int unsigned   cyc = 0;
    int unsigned   hit_cnt = 0;
    done_t         done_q[$];
    logic [AW-1:0] addr_q[$];
    bit            dp_cache [0:32767];
    bit            ref_cache[0:32767];
    bit            abort = 1'b0;
    logic          pre_en = 1'b0;
    logic [AW-1:0] pre_addr = '0;

    assign hit = dp_cache[address];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: unexpected event (t=%0t)", name, $time);
    endtask

    // Datapath model plus output monitor, sampled on the falling edge
    initial begin
        int unsigned memrun = 0;
        bit prev_chk = 0, prev_hit = 0, prev_wr = 0;
        done_t d;
        forever begin
            @(negedge clk);
            if (pre_en) dp_cache[pre_addr] = 1'b1;
            if (!rstN || abort) begin
                memrun = 0; prev_chk = 0; prev_hit = 0; prev_wr = 0;
            end else begin
                if (writeCache) dp_cache[address] = 1'b1;
                if (hitCountEn) hit_cnt++;
                if ((int'(checkHit) + int'(readCache) + int'(writeCache) + int'(readMem)) > 1)
                    fail_now("strobes_exclusive");
                if (checkHit) begin
                    if (addr_q.size() == 0) fail_now("extra_check");
                    else check("check_addr", address, addr_q.pop_front());
                end
                if (hitCountEn) check("hit_path", readCache && prev_chk && prev_hit, 1);
                if (readCache && !hitCountEn) check("rdout_after_fill", prev_wr, 1);
                if (readMem) begin
                    memrun++;
                end else if (memrun != 0) begin
                    check("mem_len", memrun, MEM_LAT);
                    check("fill_after_mem", writeCache, 1);
                    memrun = 0;
                end
                if (done) begin
                    if (done_q.size() == 0) begin
                        fail_now("extra_done");
                    end else begin
                        d = done_q.pop_front();
                        check("done_cycle", cyc, d.cyc);
                        check("miss_count", missCount, d.miss);
                        check("hit_delta", hit_cnt - d.hbase, d.hits);
                        check("busy_at_done", busy, 1);
                    end
                end
                prev_chk = checkHit;
                prev_hit = hit;
                prev_wr  = writeCache;
            end
        end
    end

    // Reference model: predicts the whole run from the cache contents, then starts it
    task automatic issue(input logic [AW-1:0] b, input int unsigned n);
        done_t d;
        int unsigned tot = 0, ms = 0, hs = 0;
        logic [AW-1:0] a;
        for (int i = 0; i < int'(n); i++) begin
            a = b + AW'(i);
            addr_q.push_back(a);
            if (ref_cache[a]) begin
                tot += 3; hs++;
            end else begin
                tot += MEM_LAT + 4; ms++; ref_cache[a] = 1'b1;
            end
        end
        d.cyc   = cyc + 1 + tot;
        d.miss  = (ms > 8191) ? 8191 : ms;
        d.hits  = hs;
        d.hbase = hit_cnt;
        done_q.push_back(d);
        baseAddr    = b;
        numAccesses = CW'(n);
        start       = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((done_q.size() != 0 || busy) && k < 3000) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 3000) begin
            fail_now("run_timeout");
            done_q.delete();
        end
        check("addr_q_drained", addr_q.size(), 0);
        addr_q.delete();
    endtask

    task automatic preload(input logic [AW-1:0] a);
        ref_cache[a] = 1'b1;
        pre_addr = a;
        pre_en   = 1'b1;
        @(posedge clk); #1;
        pre_en = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int unsigned seen;
        int unsigned hb;
        int k;
        repeat (3) @(posedge clk);
        #1;
        check("reset_strobes", {checkHit, readCache, writeCache, readMem, hitCountEn, busy, done}, 0);
        check("reset_address", address, 0);
        check("reset_miss", missCount, 0);
        rstN = 1'b1;
        @(posedge clk); #1;

        // Reset in the middle of a miss fill
        issue(15'h1234, 1);
        @(posedge clk); #1;
        check("in_mem", readMem, 1);
        abort = 1'b1;
        rstN  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstN = 1'b1;
        check("abort_strobes", {checkHit, readCache, writeCache, readMem, hitCountEn, busy, done}, 0);
        check("abort_miss", missCount, 0);
        check("abort_address", address, 0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            seen += int'(writeCache) + int'(busy) + int'(readCache);
        end
        check("quiet_after_abort", seen, 0);
        addr_q.delete();
        done_q.delete();
        ref_cache[15'h1234] = 1'b0;
        abort = 1'b0;

        // Cold miss, then the same address hits
        issue(15'h0400, 1);
        wait_idle();
        check("cold_miss_count", missCount, 1);
        issue(15'h0400, 1);
        wait_idle();
        check("rerun_miss_count", missCount, 0);

        // Zero-length run
        issue(15'h0000, 0);
        check("zero_done", done, 1);
        check("zero_busy", busy, 1);
        @(posedge clk); #1;
        check("zero_busy_after", busy, 0);
        wait_idle();

        // Address wrap
        issue(15'h7FFF, 2);
        wait_idle();

        // Start pulses during MEM and in DONE are ignored
        issue(15'h2000, 2);
        @(posedge clk); #1;
        baseAddr = AW'($urandom);
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (!done && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        check("saw_done", done, 1);
        baseAddr = AW'($urandom);
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle();
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            seen += int'(busy);
        end
        check("no_second_run", seen, 0);

        // Mixed stream: half preloaded
        for (int i = 0; i < 4; i++) preload(AW'(i));
        hb = hit_cnt;
        issue(15'h0000, 8);
        wait_idle();
        check("mixed_miss", missCount, 4);
        check("mixed_hits", hit_cnt - hb, 4);

        // Randomized runs with random preloads, back to back
        for (int r = 0; r < 25; r++) begin
            for (int p = 0; p < 2; p++) preload(15'h3000 + AW'($urandom_range(0, 70)));
            issue(15'h3000 + AW'($urandom_range(0, 63)), $urandom_range(0, 6));
            wait_idle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
